// File: rtl/door_motor_ctrl.sv
// Door motor controller: drives the open/close motor from the limit switches,
// the obstruction sensor and the upstream open request, with hold and motion timeouts.
module door_motor_ctrl #(
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       doorOpen,
  input  logic       limOpen,
  input  logic       limClosed,
  input  logic       obstruct,
  output logic       motorOpen,
  output logic       motorClose,
  output logic [2:0] doorState,
  output logic       fault
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } stateT;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] moveCnt;
  logic [CNT_W-1:0] holdCnt;
  logic             moveDone;
  logic             holdDone;
  logic             idle;

  assign moveDone = (moveCnt == TIMEOUT_LAST);
  assign holdDone = (holdCnt == HOLD_LAST);
  assign idle     = !doorOpen && !obstruct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLOSED;
    end else begin
      state <= nextState;
    end
  end

  // Conflicting limit switches always fault first; in CLOSING a reopen request beats limClosed.
  always_comb begin
    nextState = state;
    case (state)
      CLOSED: begin
        if (doorOpen) nextState = OPENING;
      end
      OPENING: begin
        if (limOpen && limClosed) nextState = FAULT;
        else if (limOpen)         nextState = OPEN;
        else if (moveDone)        nextState = FAULT;
      end
      OPEN: begin
        if (holdDone && idle) nextState = CLOSING;
      end
      CLOSING: begin
        if (limOpen && limClosed)     nextState = FAULT;
        else if (obstruct || doorOpen) nextState = OPENING;
        else if (limClosed)            nextState = CLOSED;
        else if (moveDone)             nextState = FAULT;
      end
      FAULT: begin
        nextState = FAULT;
      end
      default: begin
        nextState = FAULT;
      end
    endcase
  end

  // Any state change (including a CLOSING->OPENING reversal) restarts both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moveCnt <= '0;
      holdCnt <= '0;
    end else if (nextState != state) begin
      moveCnt <= '0;
      holdCnt <= '0;
    end else begin
      if ((state == OPENING || state == CLOSING) && moveCnt != CNT_MAX) begin
        moveCnt <= moveCnt + CNT_W'(1);
      end
      if (state == OPEN) begin
        if (!idle) begin
          holdCnt <= '0;
        end else if (holdCnt != CNT_MAX) begin
          holdCnt <= holdCnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    motorOpen  = (state == OPENING);
    motorClose = (state == CLOSING);
    fault      = (state == FAULT);
    doorState  = state;
  end

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Directed bench for door_motor_ctrl: walks normal, reopen, hold, timeout,
// conflict and async-reset scenarios against hand-computed states.
module tb_door_motor_ctrl;

  logic       clk;
  logic       rst_n;
  logic       doorOpen;
  logic       limOpen;
  logic       limClosed;
  logic       obstruct;
  logic       motorOpen;
  logic       motorClose;
  logic [2:0] doorState;
  logic       fault;

  int checks = 0;
  int errors = 0;

  door_motor_ctrl #(
    .HOLD_CYCLES(8),
    .TIMEOUT_CYCLES(32),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .doorOpen(doorOpen),
    .limOpen(limOpen),
    .limClosed(limClosed),
    .obstruct(obstruct),
    .motorOpen(motorOpen),
    .motorClose(motorClose),
    .doorState(doorState),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic dOpen, input logic lOpen,
                               input logic lClosed, input logic obs);
    doorOpen  = dOpen;
    limOpen   = lOpen;
    limClosed = lClosed;
    obstruct  = obs;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOne(input string tag, input logic [2:0] observed,
                          input logic [2:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Expected outputs follow directly from the expected state code.
  task automatic checkOutput(input string tag, input logic [2:0] expState);
    checkOne({tag, ".doorState"},  doorState,         expState);
    checkOne({tag, ".motorOpen"},  {2'b00, motorOpen},  {2'b00, expState == 3'd1});
    checkOne({tag, ".motorClose"}, {2'b00, motorClose}, {2'b00, expState == 3'd3});
    checkOne({tag, ".fault"},      {2'b00, fault},      {2'b00, expState == 3'd4});
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("resetAsync", 3'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("idleClosed", 3'd0);

    $display("[TB] normal open/close cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("openReq", 3'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("opening", 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("reachedOpen", 3'd2);
    tick(7);
    checkOutput("hold7", 3'd2);
    tick(1);
    checkOutput("hold8Close", 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("closing", 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("closedAgain", 3'd0);

    $display("[TB] reopen on obstruction");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("reopenReq", 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    tick(8);
    checkOutput("reopenClosing", 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("obstructReverse", 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(9);
    checkOutput("closingAgain", 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("obstructBeatsLim", 3'd1);

    $display("[TB] hold extension and restart");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("openHeld", 3'd2);
    tick(19);
    checkOutput("held20", 3'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);
    checkOutput("release7", 3'd2);
    tick(1);
    checkOutput("release8", 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("openForRestart", 3'd2);
    tick(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);
    checkOutput("restart7", 3'd2);
    tick(1);
    checkOutput("restart8", 3'd3);

    $display("[TB] async reset while opening");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("reverseByRequest", 3'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncDrop", 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checkOutput("closedDespiteLimOpen", 3'd0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("firstEdgeOpens", 3'd1);

    $display("[TB] motion timeout");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(31);
    checkOutput("timeout31", 3'd1);
    tick(1);
    checkOutput("timeout32", 3'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick(3);
    checkOutput("faultSticky", 3'd4);

    $display("[TB] limit switch conflict");
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("faultCleared", 3'd0);
    tick(1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("conflictOpening", 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("conflictFault", 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
